// File: rtl/cpu_trace_buffer.sv
// Execution trace capture: records retired instructions into a circular buffer,
// triggers on a PC match or forced trigger, captures POST_TRIG more entries, then
// drains the frozen trace oldest-first over a valid/ready stream.
// Optional per-entry cycle timestamp (rd_ts port) when TRACE_TIMESTAMP_EN is defined.
module cpu_trace_buffer #(
  parameter  int PC_W      = 8,
  parameter  int DATA_W    = 8,
  parameter  int NREG      = 8,
  parameter  int FLAG_W    = 4,
  parameter  int DEPTH     = 16,
  parameter  int POST_TRIG = 8,
  parameter  int TS_W      = 16,
  localparam int REG_AW    = $clog2(NREG),
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [PC_W-1:0]   trig_pc,
  input  logic              trig_force,
  input  logic              ret_valid,
  input  logic [PC_W-1:0]   ret_pc,
  input  logic              ret_we,
  input  logic [REG_AW-1:0] ret_waddr,
  input  logic [DATA_W-1:0] ret_wdata,
  input  logic [FLAG_W-1:0] ret_flags,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [PC_W-1:0]   rd_pc,
  output logic              rd_we,
  output logic [REG_AW-1:0] rd_waddr,
  output logic [DATA_W-1:0] rd_wdata,
  output logic [FLAG_W-1:0] rd_flags,
`ifdef TRACE_TIMESTAMP_EN
  output logic [TS_W-1:0]   rd_ts,
`endif
  output logic              rd_last,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("cpu_trace_buffer: DEPTH must be a power of two and at least 2");
  end
  if ((POST_TRIG < 0) || (POST_TRIG >= DEPTH)) begin : g_bad_post
    $error("cpu_trace_buffer: POST_TRIG must lie in [0, DEPTH)");
  end
  if (TS_W < 1) begin : g_bad_ts
    $error("cpu_trace_buffer: TS_W must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    POST  = 2'b10,
    DONE  = 2'b11
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              we;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [FLAG_W-1:0] flags;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
  } entry_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]   rd_ptr, rd_ptr_nxt;
  logic [PTR_W-1:0]   post_cnt, post_cnt_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [CNT_W-1:0]   remaining, remaining_nxt;
  logic               wrapped, wrapped_nxt;
  logic               trig_hit;
  logic               wr_en;
  logic               rd_fire;
  entry_t             entry_in;
  entry_t             rd_entry;
  entry_t             mem [DEPTH];

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]    ts;

  // Free-running only while capturing; frozen in IDLE/DONE, restarted by arm.
  always_ff @(posedge clk) begin
    if (rst)                                ts <= '0;
    else if (state == IDLE && arm && !abort) ts <= '0;
    else if (state == ARMED || state == POST) ts <= ts + 1'b1;
  end
`endif

  assign trig_hit = (ret_valid && (ret_pc == trig_pc)) || trig_force;
  assign wr_en    = ret_valid && !abort && !rst && (state == ARMED || state == POST);
  assign rd_fire  = rd_valid && rd_ready;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      post_cnt  <= '0;
      count     <= '0;
      remaining <= '0;
      wrapped   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      post_cnt  <= post_cnt_nxt;
      count     <= count_nxt;
      remaining <= remaining_nxt;
      wrapped   <= wrapped_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: each combinational result is defaulted first so no path can infer a latch.
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (arm) state_nxt = ARMED;
        ARMED:   if (trig_hit) state_nxt = (POST_TRIG == 0) ? DONE : POST;
        POST:    if (ret_valid && post_cnt == PTR_W'(1)) state_nxt = DONE;
        DONE:    if (remaining == '0 || (rd_fire && rd_last)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Pointer and counter updates
  always_comb begin
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    post_cnt_nxt  = post_cnt;
    count_nxt     = count;
    remaining_nxt = remaining;
    wrapped_nxt   = wrapped;
    if (abort) begin
      wr_ptr_nxt    = '0;
      rd_ptr_nxt    = '0;
      post_cnt_nxt  = '0;
      count_nxt     = '0;
      remaining_nxt = '0;
      wrapped_nxt   = 1'b0;
    end else begin
      if (state == IDLE && arm) begin
        wr_ptr_nxt  = '0;
        count_nxt   = '0;
        wrapped_nxt = 1'b0;
      end
      if (wr_en) begin
        wr_ptr_nxt = wr_ptr + 1'b1;
        if (count != CNT_W'(DEPTH)) count_nxt = count + 1'b1;
        if (wr_ptr == PTR_W'(DEPTH - 1)) wrapped_nxt = 1'b1;
      end
      if (state == ARMED && trig_hit) post_cnt_nxt = PTR_W'(POST_TRIG);
      else if (state == POST && ret_valid) post_cnt_nxt = post_cnt - 1'b1;
      // Oldest entry sits at wr_ptr once the buffer has wrapped, else at slot 0.
      if (state != DONE && state_nxt == DONE) begin
        rd_ptr_nxt    = wrapped_nxt ? wr_ptr_nxt : '0;
        remaining_nxt = count_nxt;
      end else if (rd_fire) begin
        rd_ptr_nxt    = rd_ptr + 1'b1;
        remaining_nxt = remaining - 1'b1;
      end
    end
  end

  always_comb begin
    entry_in       = '0;
    entry_in.pc    = ret_pc;
    entry_in.we    = ret_we;
    entry_in.waddr = ret_waddr;
    entry_in.wdata = ret_wdata;
    entry_in.flags = ret_flags;
`ifdef TRACE_TIMESTAMP_EN
    entry_in.ts    = ts;
`endif
  end

  // NOTE: trace storage has no reset; pointers and count alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= entry_in;
  end

  // Output logic
  always_comb begin
    rd_entry = mem[rd_ptr];
    rd_valid = (state == DONE) && (remaining != '0);
    rd_last  = rd_valid && (remaining == CNT_W'(1));
    rd_pc    = rd_entry.pc;
    rd_we    = rd_entry.we;
    rd_waddr = rd_entry.waddr;
    rd_wdata = rd_entry.wdata;
    rd_flags = rd_entry.flags;
`ifdef TRACE_TIMESTAMP_EN
    rd_ts    = rd_entry.ts;
`endif
    state_o  = state;
    count_o  = count;
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed self-checking bench for cpu_trace_buffer: default build plus a
// POST_TRIG=0 instance; timestamp checks compile only with TRACE_TIMESTAMP_EN.
`timescale 1ns/1ps
module tb_cpu_trace_buffer;
  localparam int TS_W = 16;

  logic       clk = 1'b0;
  logic       rst, arm, abort, trig_force, ret_valid, ret_we, rd_ready;
  logic [7:0] trig_pc, ret_pc, ret_wdata;
  logic [2:0] ret_waddr;
  logic [3:0] ret_flags;
  logic       rd_valid, rd_we, rd_last;
  logic [7:0] rd_pc, rd_wdata;
  logic [2:0] rd_waddr;
  logic [3:0] rd_flags;
  logic [1:0] state_o;
  logic [4:0] count_o;

  logic       arm0, abort0, trig_force0;
  logic       z_rd_valid, z_rd_we, z_rd_last;
  logic [7:0] z_rd_pc, z_rd_wdata;
  logic [2:0] z_rd_waddr;
  logic [3:0] z_rd_flags;
  logic [1:0] z_state;
  logic [4:0] z_count;
`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] rd_ts, z_rd_ts;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cpu_trace_buffer u_dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig_pc(trig_pc),
    .trig_force(trig_force), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_we(ret_we),
    .ret_waddr(ret_waddr), .ret_wdata(ret_wdata), .ret_flags(ret_flags),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_we(rd_we),
    .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_flags(rd_flags),
`ifdef TRACE_TIMESTAMP_EN
    .rd_ts(rd_ts),
`endif
    .rd_last(rd_last), .state_o(state_o), .count_o(count_o)
  );

  cpu_trace_buffer #(.POST_TRIG(0)) u_dut0 (
    .clk(clk), .rst(rst), .arm(arm0), .abort(abort0), .trig_pc(trig_pc),
    .trig_force(trig_force0), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_we(ret_we),
    .ret_waddr(ret_waddr), .ret_wdata(ret_wdata), .ret_flags(ret_flags),
    .rd_valid(z_rd_valid), .rd_ready(rd_ready), .rd_pc(z_rd_pc), .rd_we(z_rd_we),
    .rd_waddr(z_rd_waddr), .rd_wdata(z_rd_wdata), .rd_flags(z_rd_flags),
`ifdef TRACE_TIMESTAMP_EN
    .rd_ts(z_rd_ts),
`endif
    .rd_last(z_rd_last), .state_o(z_state), .count_o(z_count)
  );

  // Entry fields derived from the PC so every entry is distinguishable.
  function automatic logic [23:0] exp_entry(input int pc);
    logic [7:0] p;
    logic [7:0] d;
    p = pc[7:0];
    d = p * 8'd7 + 8'd1;
    return {p, p[0] ^ p[2], p[2:0], d, ~p[3:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input int pc);
    logic [23:0] e;
    e = exp_entry(pc);
    ret_valid = 1'b1;
    {ret_pc, ret_we, ret_waddr, ret_wdata, ret_flags} = e;
    tick();
    ret_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Drains n entries expected to carry PCs first_pc.., optional ready pattern 1,0,0,1.
  task automatic drain(input string name, input int first_pc, input int n,
                       input bit bp, input bit ts_mode);
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    while (k < n && cyc < 200) begin
      rd_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (rd_valid) begin
        vectors++;
        if ({rd_pc, rd_we, rd_waddr, rd_wdata, rd_flags} !== exp_entry(first_pc + k)) begin
          miscompares++;
          $display("FAIL %s entry %0d: got %h expected %h", name, k,
                   {rd_pc, rd_we, rd_waddr, rd_wdata, rd_flags}, exp_entry(first_pc + k));
        end
        vectors++;
        if (rd_last !== (k == n - 1)) begin
          miscompares++;
          $display("FAIL %s rd_last at entry %0d: got %b expected %b", name, k, rd_last, (k == n - 1));
        end
`ifdef TRACE_TIMESTAMP_EN
        if (ts_mode) begin
          vectors++;
          if (rd_ts !== TS_W'(2 * k + 1)) begin
            miscompares++;
            $display("FAIL %s rd_ts at entry %0d: got %0d expected %0d", name, k, rd_ts, 2 * k + 1);
          end
        end
`else
        if (ts_mode) $display("note: timestamp checks need TRACE_TIMESTAMP_EN");
`endif
        if (rd_ready) k++;
      end
      tick();
      cyc++;
    end
    rd_ready = 1'b0;
    vectors++;
    if (k != n) begin
      miscompares++;
      $display("FAIL %s drained count: got %0d expected %0d", name, k, n);
    end
    vectors++;
    if (state_o !== 2'b00 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s post-drain state/rd_valid: got %b/%b expected 00/0", name, state_o, rd_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 0; abort = 0; trig_force = 0; ret_valid = 0; rd_ready = 0;
    arm0 = 0; abort0 = 0; trig_force0 = 0; trig_pc = 0;
    ret_pc = 0; ret_we = 0; ret_waddr = 0; ret_wdata = 0; ret_flags = 0;
    tick(); tick();
    rst = 1'b0;
    vectors++;
    if ({state_o, count_o, rd_valid, rd_last} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset state/count/valid/last: got %b expected 0", {state_o, count_o, rd_valid, rd_last});
    end
    vectors++;
    if ({z_state, z_count, z_rd_valid} !== 8'b0) begin
      miscompares++;
      $display("FAIL reset post0 instance: got %b expected 0", {z_state, z_count, z_rd_valid});
    end
  endtask

  task automatic test_basic(input string name, input bit bp);
    trig_pc = 8'd3;
    do_arm();
    vectors++;
    if (state_o !== 2'b01) begin
      miscompares++;
      $display("FAIL %s armed: got %b expected 01", name, state_o);
    end
    for (int pc = 0; pc < 12; pc++) begin
      retire(pc);
      if (pc == 2 || pc == 3) begin
        vectors++;
        if (state_o !== ((pc == 3) ? 2'b10 : 2'b01)) begin
          miscompares++;
          $display("FAIL %s state after pc %0d: got %b", name, pc, state_o);
        end
      end
    end
    vectors++;
    if (state_o !== 2'b11 || count_o !== 5'd12 || rd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done: got state %b count %0d valid %b expected 11 12 1", name, state_o, count_o, rd_valid);
    end
    drain(name, 0, 12, bp, 1'b0);
  endtask

  task automatic test_wrap();
    trig_pc = 8'd30;
    do_arm();
    for (int pc = 0; pc < 39; pc++) retire(pc);
    vectors++;
    if (state_o !== 2'b11) begin
      miscompares++;
      $display("FAIL wrap done after pc 38: got %b expected 11", state_o);
    end
    retire(39);
    vectors++;
    if (count_o !== 5'd16) begin
      miscompares++;
      $display("FAIL wrap count: got %0d expected 16", count_o);
    end
    drain("wrap", 23, 16, 1'b0, 1'b0);
  endtask

  task automatic test_post0();
    arm0 = 1'b1; tick(); arm0 = 1'b0;
    vectors++;
    if (z_state !== 2'b01) begin
      miscompares++;
      $display("FAIL post0 armed: got %b expected 01", z_state);
    end
    trig_force0 = 1'b1; tick(); trig_force0 = 1'b0;
    vectors++;
    if (z_state !== 2'b11 || z_rd_valid !== 1'b0 || z_count !== 5'd0) begin
      miscompares++;
      $display("FAIL post0 done: got state %b valid %b count %0d expected 11 0 0", z_state, z_rd_valid, z_count);
    end
    tick();
    vectors++;
    if (z_state !== 2'b00 || z_rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post0 return idle: got state %b valid %b expected 00 0", z_state, z_rd_valid);
    end
  endtask

  task automatic test_abort();
    trig_pc = 8'd2;
    do_arm();
    for (int pc = 0; pc < 5; pc++) retire(pc);
    vectors++;
    if (state_o !== 2'b10) begin
      miscompares++;
      $display("FAIL abort setup post: got %b expected 10", state_o);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    vectors++;
    if (state_o !== 2'b00 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort in post: got state %b valid %b expected 00 0", state_o, rd_valid);
    end
    trig_pc = 8'd3;
    do_arm();
    for (int pc = 0; pc < 12; pc++) retire(pc);
    rd_ready = 1'b1; tick(); tick(); rd_ready = 1'b0;
    vectors++;
    if (rd_valid !== 1'b1 || rd_pc !== 8'd2) begin
      miscompares++;
      $display("FAIL abort mid-drain position: got valid %b pc %0d expected 1 2", rd_valid, rd_pc);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    vectors++;
    if (state_o !== 2'b00 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort mid-drain: got state %b valid %b expected 00 0", state_o, rd_valid);
    end
    do_arm();
    for (int pc = 0; pc < 12; pc++) retire(pc);
    do_arm();
    vectors++;
    if (state_o !== 2'b11 || rd_valid !== 1'b1 || rd_pc !== 8'd0) begin
      miscompares++;
      $display("FAIL arm in done: got state %b valid %b pc %0d expected 11 1 0", state_o, rd_valid, rd_pc);
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    trig_pc = 8'd3;
    do_arm();
    for (int pc = 0; pc < 5; pc++) retire(pc);
    rst = 1'b1; tick(); rst = 1'b0;
    vectors++;
    if ({state_o, count_o, rd_valid, rd_last} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset mid-capture: got %b expected 0", {state_o, count_o, rd_valid, rd_last});
    end
  endtask

`ifdef TRACE_TIMESTAMP_EN
  task automatic test_timestamp();
    trig_pc = 8'd3;
    do_arm();
    for (int pc = 0; pc < 12; pc++) begin
      tick();
      retire(pc);
    end
    vectors++;
    if (state_o !== 2'b11) begin
      miscompares++;
      $display("FAIL timestamp done: got %b expected 11", state_o);
    end
    drain("timestamp", 0, 12, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic("basic", 1'b0);
    test_wrap();
    test_basic("backpressure", 1'b1);
    test_post0();
    test_abort();
`ifdef TRACE_TIMESTAMP_EN
    test_timestamp();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
